hssi_rx_pkt_buf: RTL



---
 rtl/ofs_fim_eth_if_pkg.sv | 19 +
 rtl/hssi_rx_pkt_buf_ram.sv | 27 ++
 rtl/hssi_rx_pkt_buf.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_eth_if_pkg.sv
// Shared Ethernet RX stream definitions: tuser layout, counter width, write-side FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package ofs_fim_eth_if_pkg;

    localparam int ETH_TUSER_W = 8;
    localparam int ETH_ERR_BIT = 0;
    localparam int ETH_CNT_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        DROP = 2'd2
    } wr_state_e;

    function automatic logic [ETH_CNT_W-1:0] sat_inc(input logic [ETH_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hssi_rx_pkt_buf_ram.sv
// Simple dual-port packet RAM, one-cycle registered read.
// Read data holds while rd_en_i is low; no back-pressure of its own.
module hssi_rx_pkt_buf_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_dat_o
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/hssi_rx_pkt_buf.sv
// Store-and-forward RX frame buffer: input never stalls; overflowing or errored frames are dropped whole.
// First beat leaves 2 cycles after its tlast is written; m_tready only gates output-stage flop enables.
module hssi_rx_pkt_buf
    import ofs_fim_eth_if_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int USER_W     = ETH_TUSER_W,
    parameter int DEPTH_LOG2 = 9,
    parameter int DROP_ERR   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tvalid,
    input  logic [DATA_W-1:0]    s_tdata,
    input  logic [DATA_W/8-1:0]  s_tkeep,
    input  logic                 s_tlast,
    input  logic [USER_W-1:0]    s_tuser,
    output logic                 m_tvalid,
    output logic [DATA_W-1:0]    m_tdata,
    output logic [DATA_W/8-1:0]  m_tkeep,
    output logic                 m_tlast,
    output logic [USER_W-1:0]    m_tuser,
    input  logic                 m_tready,
    output logic [ETH_CNT_W-1:0] drop_cnt,
    output logic                 overflow_pulse
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int PW     = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef struct packed {
        logic [USER_W-1:0] user;
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

    wr_state_e            state_q;
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        commit_ptr_q;
    logic [PW-1:0]        fetch_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [ETH_CNT_W-1:0] drop_cnt_q;
    logic                 overflow_q;
    logic                 a_vld_q;
    logic                 b_vld_q;
    beat_t                b_dat_q;

    logic  full;
    logic  err_eop;
    logic  ram_we;
    logic  rd_issue;
    logic  pop;
    beat_t wr_beat;
    beat_t ram_rd_dat;
    beat_t m_beat;

    // Occupancy is measured against beats actually released to the AFU, so
    // entries parked in the output stage are never overwritten.
    assign full    = (wr_ptr_q - rd_ptr_q) == FULL_OCC;
    assign err_eop = (DROP_ERR != 0) && s_tuser[ETH_ERR_BIT];
    assign ram_we  = s_tvalid && (state_q != DROP) && !full;
    assign wr_beat = '{user: s_tuser, last: s_tlast, keep: s_tkeep, data: s_tdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (s_tvalid) begin
                case (state_q)
                    IDLE, WR: begin
                        if (full) begin
                            wr_ptr_q   <= commit_ptr_q;
                            overflow_q <= 1'b1;
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                            state_q    <= s_tlast ? IDLE : DROP;
                        end else if (s_tlast && err_eop) begin
                            wr_ptr_q   <= commit_ptr_q;
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                            state_q    <= IDLE;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            if (s_tlast) begin
                                commit_ptr_q <= wr_ptr_q + 1'b1;
                            end
                            state_q <= s_tlast ? IDLE : WR;
                        end
                    end
                    DROP: begin
                        if (s_tlast) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    hssi_rx_pkt_buf_ram #(
        .WIDTH ($bits(beat_t)),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_dat_i  (wr_beat),
        .rd_en_i   (rd_issue),
        .rd_addr_i (fetch_ptr_q[DEPTH_LOG2-1:0]),
        .rd_dat_o  (ram_rd_dat)
    );

    // Stage A is the RAM read register, stage B the skid slot holding the older beat.
    assign rd_issue = (fetch_ptr_q != commit_ptr_q) && !b_vld_q;
    assign m_tvalid = a_vld_q || b_vld_q;
    assign pop      = m_tvalid && m_tready;
    assign m_beat   = b_vld_q ? b_dat_q : ram_rd_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            a_vld_q     <= 1'b0;
            b_vld_q     <= 1'b0;
        end else begin
            if (rd_issue) begin
                fetch_ptr_q <= fetch_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (b_vld_q) begin
                if (pop) begin
                    b_vld_q <= 1'b0;
                end
            end else if (rd_issue) begin
                a_vld_q <= 1'b1;
                if (a_vld_q && !pop) begin
                    b_vld_q <= 1'b1;
                end
            end else if (pop) begin
                a_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!b_vld_q && rd_issue && a_vld_q && !pop) begin
            b_dat_q <= ram_rd_dat;
        end
    end

    assign m_tdata        = m_beat.data;
    assign m_tkeep        = m_beat.keep;
    assign m_tlast        = m_beat.last;
    assign m_tuser        = m_beat.user;
    assign drop_cnt       = drop_cnt_q;
    assign overflow_pulse = overflow_q;

endmodule
